chip8_mem_arbiter: RTL and testbench
====================================

// Module: chip8_mem_arbiter
// PURPOSE
//  Shares the single-port 4 KB Chip-8 program/data RAM between three requesters:
//  the SPI program uploader (byte writes), the CPU (reads/writes) and the blitter (reads).
//  It sits between data_io/chip8 core logic and the block RAM, serialising accesses and
//  returning read data. It also raises an error pulse when a request starves, which feeds
//  the top-level reset circuit.
// PARAMETERS
//  ADDR_W      12    RAM address width (4096 bytes)
//  DATA_W      8     RAM data width
//  RD_LATENCY  1     block RAM read latency in clk cycles (1..3)
//  TIMEOUT     1023  max cycles a pending req may wait before timeout_err pulses
// PORTS
//  clk         in   1       system clock (all logic on posedge)
//  res         in   1       synchronous active-high reset
//  uploading   in   1       uploader session active; blocks CPU/blitter grants
//  upl_req     in   1       uploader write request (already synchronised to clk)
//  upl_addr    in   ADDR_W  uploader write address
//  upl_wdata   in   DATA_W  uploader write data
//  upl_ack     out  1       1-cycle pulse: uploader write done
//  cpu_req     in   1       CPU request, held until cpu_ack
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       1-cycle pulse: CPU access done
//  cpu_rdata   out  DATA_W  CPU read data, valid with cpu_ack, held until next CPU ack
//  blt_req     in   1       blitter read request, held until blt_ack
//  blt_addr    in   ADDR_W  blitter address
//  blt_ack     out  1       1-cycle pulse: blitter read done
//  blt_rdata   out  DATA_W  blitter read data, valid with blt_ack, held until next
//  mem_addr    out  ADDR_W  RAM address
//  mem_we      out  1       RAM write enable
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data, RD_LATENCY cycles after mem_addr
//  busy        out  1       transaction in flight (state != IDLE)
//  timeout_err out  1       1-cycle pulse on request starvation
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, RR pointer = CPU, timeout counters 0.
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//    IDLE: sample requests, pick a winner, register addr/we/wdata and winner ID.
//    ISSUE: drive mem_* for exactly 1 cycle (mem_we=1 only here, only for writes).
//    WAIT: RD_LATENCY cycles; mem_addr held, mem_we=0.
//    DONE: capture mem_rdata into winner's rdata reg (reads only) and pulse its ack.
//  - Fixed latency: req seen in IDLE -> ack in the 3+RD_LATENCY'th cycle (4 at default).
//    Writes take the same path (uniform timing).
//  - Priority: upl_req first. When uploading=1, only the uploader is granted; CPU and
//    blitter requests wait and age. Otherwise CPU vs blitter is round-robin: the granted
//    one loses priority to the other on the next contest.
//  - Req must stay high until ack; dropping req early is illegal (not checked).
//    After ack, a still-high req is treated as a new request (back-to-back allowed,
//    re-arbitrated in the next IDLE).
//  - A request arriving during ISSUE/WAIT/DONE waits for IDLE; no pre-emption.
//  - Timeout: each of cpu/blt has a counter that increments while req=1 and not
//    granted, clears on grant; at TIMEOUT it pulses timeout_err once and saturates
//    until grant. The counter is frozen (no increment) while uploading=1.
//  - Address arithmetic: none; addresses pass through unchanged (wrap is the
//    requester's job).
//  - Reset mid-transaction: next edge -> IDLE, mem_we=0, no ack is issued for the
//    aborted access, and rdata regs are cleared.
// STRUCTURE
//  - Shared header chip8_mem.vh: requester IDs (REQ_UPL/REQ_CPU/REQ_BLT), FSM state
//    encodings, default ADDR_W/DATA_W.
//  - Sub-module rr_arbiter2: 2-way round-robin picker (req[1:0] -> one-hot grant,
//    pointer updated on an 'advance' strobe). Timeout counters are inline.
// TESTING
//  - Single CPU read at addr 0x200 with RAM[0x200]=0xA2 -> cpu_ack at cycle 4 and
//    cpu_rdata=0xA2; mem_we stays 0.
//  - CPU write 0x55 to 0x300, then blitter read 0x300 -> blt_rdata=0x55; exactly one
//    mem_we pulse.
//  - cpu_req and blt_req held together for 8 transactions -> grants alternate
//    C,B,C,B..., first grant CPU after reset.
//  - uploading=1, upl writes 0x00..0x0F at 0x200.., cpu_req held -> no cpu_ack until
//    uploading=0; RAM contents match; no timeout_err.
//  - TIMEOUT=8, a stream of upl_req with uploading=0 holding off cpu_req ->
//    timeout_err single pulse after 8 waiting cycles.
//  - res asserted during WAIT of a CPU read -> no cpu_ack, busy=0 next cycle; a
//    re-request completes normally.

Source files
------------

// File: rtl/chip8_mem_arbiter_pkg.sv
// Shared types for the Chip-8 RAM arbiter: requester IDs, FSM states, default widths.
package chip8_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    REQ_UPL = 2'd0,
    REQ_CPU = 2'd1,
    REQ_BLT = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Requester and RAM-side signals of the Chip-8 RAM arbiter.
// slave: arbiter view; master: requesters + RAM view.
interface chip8_mem_arbiter_if
  import chip8_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              uploading;
  logic              upl_req;
  logic [ADDR_W-1:0] upl_addr;
  logic [DATA_W-1:0] upl_wdata;
  logic              upl_ack;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              blt_req;
  logic [ADDR_W-1:0] blt_addr;
  logic              blt_ack;
  logic [DATA_W-1:0] blt_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  uploading, upl_req, upl_addr, upl_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  blt_req, blt_addr, mem_rdata,
    output upl_ack, cpu_ack, cpu_rdata, blt_ack, blt_rdata,
    output mem_addr, mem_we, mem_wdata, busy, timeout_err
  );

  modport master (
    output uploading, upl_req, upl_addr, upl_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output blt_req, blt_addr, mem_rdata,
    input  upl_ack, cpu_ack, cpu_rdata, blt_ack, blt_rdata,
    input  mem_addr, mem_we, mem_wdata, busy, timeout_err
  );

endinterface

// File: rtl/chip8_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: index 0 = CPU, index 1 = blitter.
// The pointer names the preferred index; after an advance the granted index loses priority.
module chip8_mem_arbiter_rr_arbiter2 (
  input  logic       clk,
  input  logic       res,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_ptr;

  // One-hot grant; on contention the pointer decides.
  always_comb begin
    o_grant = '0;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
      default: o_grant = '0;
    endcase
  end

  // Pointer moves to the index that was not granted.
  always_ff @(posedge clk) begin
    if (res) begin
      r_ptr <= 1'b0;
    end else if (i_advance && (|o_grant)) begin
      r_ptr <= o_grant[0];
    end
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Chip-8 program/data RAM arbiter: uploader > (CPU <-> blitter round-robin),
// fixed-latency IDLE->ISSUE->WAIT->DONE transactions and starvation timeout.
module chip8_mem_arbiter
  import chip8_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                clk,
  input  logic                res,
  chip8_mem_arbiter_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] T_MAX    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] T_HIT    = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       LAT_LAST = 2'(RD_LATENCY - 1);

  state_e            r_state, w_next;
  req_id_e           r_owner, w_win;
  logic              w_win_valid;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_we, w_we;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [1:0]        r_lat;
  logic [DATA_W-1:0] r_cpu_rdata, r_blt_rdata;
  logic [1:0]        w_rr_req, w_rr_grant;
  logic              w_rr_adv;
  logic [1:0]        w_cb_req, w_cb_gnt, w_cb_own, w_wait, w_hit;
  logic [CNT_W-1:0]  r_cnt [2];
  logic              r_err;
  logic              w_last_wait;

  assign w_rr_req    = {bus.blt_req, bus.cpu_req} & {2{~bus.uploading}};
  assign w_rr_adv    = (r_state == ST_IDLE) && !bus.upl_req;
  assign w_last_wait = (r_state == ST_WAIT) && (r_lat == LAT_LAST);

  chip8_mem_arbiter_rr_arbiter2 u_rr (
    .clk       (clk),
    .res       (res),
    .i_req     (w_rr_req),
    .i_advance (w_rr_adv),
    .o_grant   (w_rr_grant)
  );

  // Winner selection and the access fields it would register.
  always_comb begin
    w_win_valid = 1'b0;
    w_win       = REQ_UPL;
    w_addr      = '0;
    w_we        = 1'b0;
    w_wdata     = '0;
    if (bus.upl_req) begin
      w_win_valid = 1'b1;
      w_win       = REQ_UPL;
      w_addr      = bus.upl_addr;
      w_we        = 1'b1;
      w_wdata     = bus.upl_wdata;
    end else if (w_rr_grant[0]) begin
      w_win_valid = 1'b1;
      w_win       = REQ_CPU;
      w_addr      = bus.cpu_addr;
      w_we        = bus.cpu_we;
      w_wdata     = bus.cpu_wdata;
    end else if (w_rr_grant[1]) begin
      w_win_valid = 1'b1;
      w_win       = REQ_BLT;
      w_addr      = bus.blt_addr;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_win_valid) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (r_lat == LAT_LAST) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register and the latched transaction.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_owner <= REQ_UPL;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_win_valid) begin
        r_owner <= w_win;
        r_addr  <= w_addr;
        r_we    <= w_we;
        r_wdata <= w_wdata;
        r_lat   <= '0;
      end else if (r_state == ST_WAIT) begin
        r_lat   <= r_lat + 2'd1;
      end
    end
  end

  // Read data is registered on the last WAIT edge so it is already presented
  // during DONE, together with the ack.
  always_ff @(posedge clk) begin
    if (res) begin
      r_cpu_rdata <= '0;
      r_blt_rdata <= '0;
    end else if (w_last_wait && !r_we) begin
      if (r_owner == REQ_CPU) r_cpu_rdata <= bus.mem_rdata;
      if (r_owner == REQ_BLT) r_blt_rdata <= bus.mem_rdata;
    end
  end

  // Starvation bookkeeping for CPU (index 0) and blitter (index 1).
  always_comb begin
    w_cb_req = {bus.blt_req, bus.cpu_req};
    w_cb_gnt = (r_state == ST_IDLE && !bus.upl_req) ? w_rr_grant : 2'b00;
    w_cb_own = (r_state != ST_IDLE) ? {r_owner == REQ_BLT, r_owner == REQ_CPU} : 2'b00;
    w_wait   = w_cb_req & ~w_cb_gnt & ~w_cb_own & {2{~bus.uploading}};
    w_hit    = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_hit[i] = w_wait[i] && (r_cnt[i] == T_HIT);
    end
  end

  // Wait counters saturate at TIMEOUT; the error pulses only on the crossing.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (res || !w_cb_req[i] || w_cb_gnt[i]) begin
        r_cnt[i] <= '0;
      end else if (w_wait[i] && r_cnt[i] != T_MAX) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
    r_err <= res ? 1'b0 : (|w_hit);
  end

  // Output decode.
  always_comb begin
    bus.upl_ack     = (r_state == ST_DONE) && (r_owner == REQ_UPL);
    bus.cpu_ack     = (r_state == ST_DONE) && (r_owner == REQ_CPU);
    bus.blt_ack     = (r_state == ST_DONE) && (r_owner == REQ_BLT);
    bus.cpu_rdata   = r_cpu_rdata;
    bus.blt_rdata   = r_blt_rdata;
    bus.mem_addr    = r_addr;
    bus.mem_we      = (r_state == ST_ISSUE) && r_we;
    bus.mem_wdata   = r_wdata;
    bus.busy        = (r_state != ST_IDLE);
    bus.timeout_err = r_err;
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: directed scenarios plus randomized single transactions
// checked against a behavioural RAM model and the arbitration rules.
module tb_chip8_mem_arbiter;

  localparam int RDL = 1;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  chip8_mem_arbiter #(
    .ADDR_W     (12),
    .DATA_W     (8),
    .RD_LATENCY (RDL),
    .TIMEOUT    (TMO)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // Block RAM with 1-cycle read latency, plus a preload port for the bench.
  logic [7:0]  ram [4096];
  logic [7:0]  rd_q;
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    rd_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rd_q;

  int we_cnt  = 0;
  int err_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_we)      we_cnt  <= we_cnt + 1;
    if (bus.timeout_err) err_cnt <= err_cnt + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] model [4096];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // who: 0 uploader, 1 CPU, 2 blitter. edges = posedges until ack, -1 on timeout.
  task automatic xfer(input int who, input logic we, input logic [11:0] a, input logic [7:0] d,
                      output int edges, output logic [7:0] rd);
    logic got;
    got   = 1'b0;
    edges = 0;
    case (who)
      0: begin bus.upl_req = 1'b1; bus.upl_addr = a; bus.upl_wdata = d; end
      1: begin bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; end
      default: begin bus.blt_req = 1'b1; bus.blt_addr = a; end
    endcase
    while (!got && edges < 20) begin
      tick();
      edges++;
      got = (who == 0) ? bus.upl_ack : (who == 1) ? bus.cpu_ack : bus.blt_ack;
    end
    rd = (who == 1) ? bus.cpu_rdata : bus.blt_rdata;
    bus.upl_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.blt_req = 1'b0;
    if (!got) edges = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, last_edge, n_acks, last_cb, who, we0, err0, cacks, k, gap;
    logic got, we;
    logic [7:0] rd, d;
    logic [11:0] a;

    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.uploading = 1'b0;
    bus.upl_req = 1'b0; bus.upl_addr = '0; bus.upl_wdata = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.blt_req = 1'b0; bus.blt_addr = '0;
    res = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.upl_ack, bus.cpu_ack, bus.blt_ack}, 0);
    chk("rst_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    chk("rst_rdata", {bus.cpu_rdata, bus.blt_rdata}, 0);
    chk("rst_err", bus.timeout_err, 0);
    res = 1'b0;
    tick();

    // CPU and blitter contending continuously: loser of the last contest wins the next.
    last_cb = 2;
    last_edge = -1;
    n_acks = 0;
    edges = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h010;
    bus.blt_req = 1'b1; bus.blt_addr = 12'h020;
    while (n_acks < 8 && edges < 100) begin
      tick();
      edges++;
      if (bus.cpu_ack || bus.blt_ack) begin
        who = bus.cpu_ack ? 1 : 2;
        chk($sformatf("rr_order%0d", n_acks), who, (last_cb == 1) ? 2 : 1);
        chk($sformatf("rr_single%0d", n_acks), bus.cpu_ack & bus.blt_ack, 0);
        chk($sformatf("rr_spacing%0d", n_acks), edges - last_edge, 3 + RDL);
        last_cb = who;
        last_edge = edges;
        n_acks++;
        if (n_acks == 8) begin bus.cpu_req = 1'b0; bus.blt_req = 1'b0; end
      end
    end
    bus.cpu_req = 1'b0; bus.blt_req = 1'b0;
    chk("rr_count", n_acks, 8);

    // Single CPU read of a preloaded byte
    pl_en = 1'b1; pl_addr = 12'h200; pl_data = 8'hA2; model[12'h200] = 8'hA2;
    tick();
    pl_en = 1'b0;
    chk("idle_before_read", bus.busy, 0);
    we0 = we_cnt;
    xfer(1, 1'b0, 12'h200, 8'h00, edges, rd);
    chk("rd_latency", edges, 2 + RDL);
    chk("rd_data", rd, model[12'h200]);
    chk("rd_no_we", we_cnt, we0);
    tick();
    chk("ack_width", {bus.upl_ack, bus.cpu_ack, bus.blt_ack}, 0);

    // CPU write then blitter read of the same byte
    we0 = we_cnt;
    xfer(1, 1'b1, 12'h300, 8'h55, edges, rd);
    model[12'h300] = 8'h55;
    chk("wr_latency", edges, 2 + RDL);
    tick();
    xfer(2, 1'b0, 12'h300, 8'h00, edges, rd);
    chk("blt_latency", edges, 2 + RDL);
    chk("blt_data", rd, model[12'h300]);
    chk("wr_one_pulse", we_cnt, we0 + 1);
    tick();

    // Upload session blocks a held CPU read; CPU counter frozen meanwhile
    err0 = err_cnt;
    cacks = 0;
    bus.uploading = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
    for (int i = 0; i < 16; i++) begin
      bus.upl_req = 1'b1; bus.upl_addr = 12'h200 + 12'(i); bus.upl_wdata = 8'(i);
      got = 1'b0; k = 0;
      while (!got && k < 20) begin
        tick(); k++;
        got = bus.upl_ack;
        if (bus.cpu_ack) cacks++;
      end
      chk($sformatf("upl_ack%0d", i), got, 1);
      model[12'h200 + 12'(i)] = 8'(i);
      bus.upl_req = 1'b0;
      tick();
      if (bus.cpu_ack) cacks++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cpu_ack) cacks++;
    end
    chk("upl_blocks_cpu", cacks, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("upl_ram%0d", i), ram[12'h200 + 12'(i)], model[12'h200 + 12'(i)]);
    end
    bus.uploading = 1'b0;
    got = 1'b0; k = 0;
    while (!got && k < 20) begin
      tick(); k++;
      got = bus.cpu_ack;
    end
    chk("upl_cpu_after", got, 1);
    chk("upl_cpu_data", bus.cpu_rdata, model[12'h200]);
    bus.cpu_req = 1'b0;
    chk("upl_no_err", err_cnt, err0);
    tick();

    // Uploader stream starves the CPU: one timeout pulse after TMO waiting cycles
    chk("idle_before_tmo", bus.busy, 0);
    err0 = err_cnt;
    bus.upl_req = 1'b1; bus.upl_addr = 12'h400; bus.upl_wdata = 8'h77;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h401;
    for (int j = 1; j <= 30; j++) begin
      tick();
      chk($sformatf("tmo_pulse%0d", j), bus.timeout_err, (j == TMO) ? 1 : 0);
    end
    got = bus.upl_ack; k = 0;
    while (!got && k < 20) begin
      tick(); k++;
      got = bus.upl_ack;
    end
    chk("tmo_upl_ack", got, 1);
    bus.upl_req = 1'b0;
    got = 1'b0; k = 0;
    while (!got && k < 20) begin
      tick(); k++;
      got = bus.cpu_ack;
    end
    chk("tmo_cpu_ack", got, 1);
    bus.cpu_req = 1'b0;
    chk("tmo_single", err_cnt, err0 + 1);
    tick();

    // Reset during WAIT of a CPU read aborts it
    xfer(1, 1'b0, 12'h201, 8'h00, edges, rd);
    chk("pre_rst_data", rd, model[12'h201]);
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h203;
    tick(); tick();
    chk("mid_busy", bus.busy, 1);
    res = 1'b1;
    tick();
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ack", bus.cpu_ack, 0);
    chk("mid_rst_rdata", {bus.cpu_rdata, bus.blt_rdata}, 0);
    chk("mid_rst_we", bus.mem_we, 0);
    res = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    chk("mid_no_ack", bus.cpu_ack, 0);
    xfer(1, 1'b0, 12'h205, 8'h00, edges, rd);
    chk("rereq_latency", edges, 2 + RDL);
    chk("rereq_data", rd, model[12'h205]);
    tick();

    // Randomized single transactions over a small region
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      xfer(1, 1'b1, 12'hF00 + 12'(i), d, edges, rd);
      model[12'hF00 + 12'(i)] = d;
      tick();
    end
    for (int n = 0; n < 40; n++) begin
      who = int'($urandom_range(0, 2));
      we  = (who == 0) ? 1'b1 : (who == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      a   = 12'hF00 + 12'($urandom_range(0, 15));
      d   = 8'($urandom);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      we0 = we_cnt;
      xfer(who, we, a, d, edges, rd);
      chk($sformatf("rnd_lat%0d", n), edges, 2 + RDL);
      if (!we) chk($sformatf("rnd_data%0d", n), rd, model[a]);
      else     model[a] = d;
      chk($sformatf("rnd_we%0d", n), we_cnt, we0 + (we ? 1 : 0));
      tick();
      chk($sformatf("rnd_ackw%0d", n), {bus.upl_ack, bus.cpu_ack, bus.blt_ack}, 0);
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rnd_ram%0d", i), ram[12'hF00 + 12'(i)], model[12'hF00 + 12'(i)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
